// File: rtl/cfg_ls_stream_sel_packer.sv
// Packs per-bank load/store stream-select fields into 32-bit cfg words and writes them out over valid/ready.
// Optional CFG_LS_PACK_SKIP_UNCHANGED_EN: skip words identical to the last value written.
module cfg_ls_stream_sel_packer #(
   parameter int N_BANKS_GROUP           = 4,
   parameter int N_BANKS_PER_STREAM      = 4,
   parameter int LOG_N_AGE_PER_STREAM    = 3,
   parameter int LOG_N_PE_PER_GROUP      = 4,
   parameter int N_CFG_REGS_LOAD_STREAM  =
      (N_BANKS_GROUP * N_BANKS_PER_STREAM * LOG_N_AGE_PER_STREAM + 31) / 32,
   parameter int N_CFG_REGS_STORE_STREAM =
      (N_BANKS_GROUP * N_BANKS_PER_STREAM * LOG_N_PE_PER_GROUP + 31) / 32,
   parameter int IDX_W =
      (((N_CFG_REGS_LOAD_STREAM > N_CFG_REGS_STORE_STREAM) ?
        N_CFG_REGS_LOAD_STREAM : N_CFG_REGS_STORE_STREAM) > 1) ?
      $clog2((N_CFG_REGS_LOAD_STREAM > N_CFG_REGS_STORE_STREAM) ?
             N_CFG_REGS_LOAD_STREAM : N_CFG_REGS_STORE_STREAM) : 1
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic start_i,
   input  logic [N_BANKS_GROUP-1:0][N_BANKS_PER_STREAM-1:0][LOG_N_AGE_PER_STREAM-1:0] l_stream_sel_i,
   input  logic [N_BANKS_GROUP-1:0][N_BANKS_PER_STREAM-1:0][LOG_N_PE_PER_GROUP-1:0]   s_stream_sel_i,
   output logic             wr_valid_o,
   input  logic             wr_ready_i,
   output logic             wr_store_o,
   output logic [IDX_W-1:0] wr_idx_o,
   output logic [31:0]      wr_data_o,
   output logic             busy_o,
   output logic             done_o
);

   localparam int WL           = LOG_N_AGE_PER_STREAM;
   localparam int WS           = LOG_N_PE_PER_GROUP;
   localparam int LOAD_FLAT_W  = N_CFG_REGS_LOAD_STREAM * 32;
   localparam int STORE_FLAT_W = N_CFG_REGS_STORE_STREAM * 32;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      STORE,
      DONE
   } state_t;

   state_t state, state_nxt;
   logic [IDX_W-1:0] idx, idx_nxt;

   logic [N_BANKS_GROUP-1:0][N_BANKS_PER_STREAM-1:0][WL-1:0] l_snap;
   logic [N_BANKS_GROUP-1:0][N_BANKS_PER_STREAM-1:0][WS-1:0] s_snap;

   logic [LOAD_FLAT_W-1:0]  load_flat;
   logic [STORE_FLAT_W-1:0] store_flat;
   logic [31:0] load_word, store_word, cur_word;
   logic in_word, skip, advance;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state  <= IDLE;
         idx    <= '0;
         l_snap <= '0;
         s_snap <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         if (state == IDLE && start_i) begin
            l_snap <= l_stream_sel_i;
            s_snap <= s_stream_sel_i;
         end
      end
   end

   // Field e = j*N_BANKS_PER_STREAM + k lands at flat bits [(e+1)*W-1 -: W]; fields may straddle words.
   always_comb begin
      load_flat  = '0;
      store_flat = '0;
      for (int j = 0; j < N_BANKS_GROUP; j++) begin
         for (int k = 0; k < N_BANKS_PER_STREAM; k++) begin
            load_flat[(j*N_BANKS_PER_STREAM + k)*WL +: WL]  = l_snap[j][k];
            store_flat[(j*N_BANKS_PER_STREAM + k)*WS +: WS] = s_snap[j][k];
         end
      end
   end

   always_comb begin
      load_word  = '0;
      store_word = '0;
      for (int n = 0; n < N_CFG_REGS_LOAD_STREAM; n++) begin
         if (idx == IDX_W'(n)) load_word = load_flat[n*32 +: 32];
      end
      for (int n = 0; n < N_CFG_REGS_STORE_STREAM; n++) begin
         if (idx == IDX_W'(n)) store_word = store_flat[n*32 +: 32];
      end
   end

   assign in_word  = (state == LOAD) || (state == STORE);
   assign cur_word = (state == STORE) ? store_word : load_word;

`ifdef CFG_LS_PACK_SKIP_UNCHANGED_EN
   logic [31:0] load_shadow  [N_CFG_REGS_LOAD_STREAM];
   logic [31:0] store_shadow [N_CFG_REGS_STORE_STREAM];
   logic        shadow_valid;
   logic [31:0] shadow_word;

   always_comb begin
      shadow_word = '0;
      for (int n = 0; n < N_CFG_REGS_LOAD_STREAM; n++) begin
         if (state == LOAD && idx == IDX_W'(n)) shadow_word = load_shadow[n];
      end
      for (int n = 0; n < N_CFG_REGS_STORE_STREAM; n++) begin
         if (state == STORE && idx == IDX_W'(n)) shadow_word = store_shadow[n];
      end
   end

   assign skip = shadow_valid && in_word && (cur_word == shadow_word);

   // Shadows only track words the register file actually accepted.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         shadow_valid <= 1'b0;
         for (int n = 0; n < N_CFG_REGS_LOAD_STREAM; n++)  load_shadow[n]  <= '0;
         for (int n = 0; n < N_CFG_REGS_STORE_STREAM; n++) store_shadow[n] <= '0;
      end else begin
         if (state == DONE) shadow_valid <= 1'b1;
         for (int n = 0; n < N_CFG_REGS_LOAD_STREAM; n++) begin
            if (wr_valid_o && wr_ready_i && state == LOAD && idx == IDX_W'(n))
               load_shadow[n] <= cur_word;
         end
         for (int n = 0; n < N_CFG_REGS_STORE_STREAM; n++) begin
            if (wr_valid_o && wr_ready_i && state == STORE && idx == IDX_W'(n))
               store_shadow[n] <= cur_word;
         end
      end
   end
`else
   assign skip = 1'b0;
`endif

   assign advance = in_word && (skip || wr_ready_i);

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      case (state)
         IDLE: begin
            if (start_i) begin
               state_nxt = LOAD;
               idx_nxt   = '0;
            end
         end
         LOAD: begin
            if (advance) begin
               if (idx == IDX_W'(N_CFG_REGS_LOAD_STREAM - 1)) begin
                  state_nxt = STORE;
                  idx_nxt   = '0;
               end else begin
                  idx_nxt = idx + 1'b1;
               end
            end
         end
         STORE: begin
            if (advance) begin
               if (idx == IDX_W'(N_CFG_REGS_STORE_STREAM - 1)) begin
                  state_nxt = DONE;
                  idx_nxt   = '0;
               end else begin
                  idx_nxt = idx + 1'b1;
               end
            end
         end
         DONE: begin
            state_nxt = IDLE;
            idx_nxt   = '0;
         end
         default: begin
            state_nxt = IDLE;
            idx_nxt   = '0;
         end
      endcase
   end

   assign wr_valid_o = in_word && !skip;
   assign wr_store_o = (state == STORE);
   assign wr_idx_o   = in_word ? idx : '0;
   assign wr_data_o  = in_word ? cur_word : '0;
   assign busy_o     = in_word;
   assign done_o     = (state == DONE);

endmodule

// File: tb/tb_cfg_ls_stream_sel_packer.sv
// Directed bench for cfg_ls_stream_sel_packer: packing, handshake timing, backpressure, reset and start rules.
module tb_cfg_ls_stream_sel_packer;

   logic clk_i;
   logic rst_n_i;
   logic start_i;
   logic [3:0][3:0][2:0] l_sel;
   logic [3:0][3:0][3:0] s_sel;
   logic        wr_valid_o;
   logic        wr_ready_i;
   logic        wr_store_o;
   logic [0:0]  wr_idx_o;
   logic [31:0] wr_data_o;
   logic        busy_o;
   logic        done_o;

   int vectors;
   int miscompares;

   int          cap_n;
   int          done_at;
   int          unstable;
   logic        cap_store [16];
   logic        cap_idx   [16];
   logic [31:0] cap_data  [16];

   cfg_ls_stream_sel_packer dut (
      .clk_i          (clk_i),
      .rst_n_i        (rst_n_i),
      .start_i        (start_i),
      .l_stream_sel_i (l_sel),
      .s_stream_sel_i (s_sel),
      .wr_valid_o     (wr_valid_o),
      .wr_ready_i     (wr_ready_i),
      .wr_store_o     (wr_store_o),
      .wr_idx_o       (wr_idx_o),
      .wr_data_o      (wr_data_o),
      .busy_o         (busy_o),
      .done_o         (done_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_n_i    = 1'b0;
      start_i    = 1'b0;
      wr_ready_i = 1'b0;
      tick();
      tick();
      rst_n_i = 1'b1;
      tick();
   endtask

   task automatic set_full_pattern();
      for (int j = 0; j < 4; j++)
         for (int k = 0; k < 4; k++)
            l_sel[j][k] = 3'b101;
      s_sel       = '0;
      s_sel[3][3] = 4'hA;
   endtask

   // Pulses start, then records every handshake until done_o (bounded).
   task automatic run_capture(input int stall, input bit disturb);
      int          wait_cnt;
      logic        h_store;
      logic        h_idx;
      logic [31:0] h_data;
      cap_n    = 0;
      done_at  = 0;
      unstable = 0;
      wait_cnt = 0;
      h_store  = 1'b0;
      h_idx    = 1'b0;
      h_data   = '0;
      start_i    = 1'b1;
      wr_ready_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int k = 1; k <= 200; k++) begin
         if (disturb && k == 2) begin
            l_sel   = '0;
            s_sel   = '1;
            start_i = 1'b1;
         end
         if (disturb && k == 3) start_i = 1'b0;
         if (done_o) begin
            done_at = k;
            break;
         end
         if (wr_valid_o) begin
            if (wait_cnt == 0) begin
               h_store = wr_store_o;
               h_idx   = wr_idx_o[0];
               h_data  = wr_data_o;
            end else if (wr_store_o !== h_store || wr_idx_o[0] !== h_idx || wr_data_o !== h_data) begin
               unstable++;
            end
            if (wait_cnt < stall) begin
               wr_ready_i = 1'b0;
               wait_cnt++;
            end else begin
               wr_ready_i = 1'b1;
               if (cap_n < 16) begin
                  cap_store[cap_n] = wr_store_o;
                  cap_idx[cap_n]   = wr_idx_o[0];
                  cap_data[cap_n]  = wr_data_o;
               end
               cap_n++;
               wait_cnt = 0;
            end
         end else begin
            wr_ready_i = 1'b1;
         end
         tick();
      end
      start_i    = 1'b0;
      wr_ready_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_n_i    = 1'b0;
      start_i    = 1'b1;
      wr_ready_i = 1'b1;
      l_sel      = '1;
      s_sel      = '1;
      tick();
      tick();
      vectors++;
      if ({wr_valid_o, wr_store_o, wr_idx_o, wr_data_o, busy_o, done_o} !== 37'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs: got valid=%b store=%b idx=%b data=%h busy=%b done=%b, want all 0",
                  wr_valid_o, wr_store_o, wr_idx_o, wr_data_o, busy_o, done_o);
      end
      start_i = 1'b0;
      rst_n_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         vectors++;
         if (wr_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL idle_ready_high: got valid=%b busy=%b done=%b, want 0 0 0",
                     wr_valid_o, busy_o, done_o);
         end
      end
      wr_ready_i = 1'b0;
   endtask

   task automatic test_single_field();
      logic [31:0] exp_d [4];
      exp_d = '{32'h001C0000, 32'h0, 32'h0, 32'h0};
      do_reset();
      l_sel       = '0;
      s_sel       = '0;
      l_sel[1][2] = 3'b111;
      run_capture(0, 1'b0);
      vectors++;
      if (cap_n !== 4 || done_at !== 5) begin
         miscompares++;
         $display("[TB] FAIL single_count: got writes=%0d done_at=%0d, want 4 and 5", cap_n, done_at);
      end
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (cap_store[i] !== (i >= 2) || cap_idx[i] !== i[0] || cap_data[i] !== exp_d[i]) begin
            miscompares++;
            $display("[TB] FAIL single_write%0d: got (%b,%b,%h), want (%b,%b,%h)",
                     i, cap_store[i], cap_idx[i], cap_data[i], (i >= 2), i[0], exp_d[i]);
         end
      end
   endtask

   task automatic test_straddle();
      logic [31:0] exp_d [4];
      exp_d = '{32'hC0000000, 32'h00000001, 32'h0, 32'h0};
      do_reset();
      l_sel       = '0;
      s_sel       = '0;
      l_sel[2][2] = 3'b111;
      run_capture(0, 1'b0);
      vectors++;
      if (cap_n !== 4) begin
         miscompares++;
         $display("[TB] FAIL straddle_count: got %0d writes, want 4", cap_n);
      end
      for (int i = 0; i < 2; i++) begin
         vectors++;
         if (cap_store[i] !== 1'b0 || cap_idx[i] !== i[0] || cap_data[i] !== exp_d[i]) begin
            miscompares++;
            $display("[TB] FAIL straddle_word%0d: got (%b,%b,%h), want (0,%b,%h)",
                     i, cap_store[i], cap_idx[i], cap_data[i], i[0], exp_d[i]);
         end
      end
   endtask

   task automatic test_full_pattern();
      logic [31:0] exp_d [4];
      exp_d = '{32'h6DB6DB6D, 32'h0000B6DB, 32'h00000000, 32'hA0000000};
      do_reset();
      set_full_pattern();
      run_capture(0, 1'b0);
      vectors++;
      if (cap_n !== 4 || done_at !== 5) begin
         miscompares++;
         $display("[TB] FAIL full_count: got writes=%0d done_at=%0d, want 4 and 5", cap_n, done_at);
      end
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (cap_store[i] !== (i >= 2) || cap_idx[i] !== i[0] || cap_data[i] !== exp_d[i]) begin
            miscompares++;
            $display("[TB] FAIL full_write%0d: got (%b,%b,%h), want (%b,%b,%h)",
                     i, cap_store[i], cap_idx[i], cap_data[i], (i >= 2), i[0], exp_d[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_d [4];
      exp_d = '{32'h6DB6DB6D, 32'h0000B6DB, 32'h00000000, 32'hA0000000};
      do_reset();
      set_full_pattern();
      run_capture(3, 1'b1);
      vectors++;
      if (cap_n !== 4 || done_at !== 17) begin
         miscompares++;
         $display("[TB] FAIL bp_count: got writes=%0d done_at=%0d, want 4 and 17", cap_n, done_at);
      end
      vectors++;
      if (unstable !== 0) begin
         miscompares++;
         $display("[TB] FAIL bp_stable: got %0d unstable stall cycles, want 0", unstable);
      end
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (cap_store[i] !== (i >= 2) || cap_idx[i] !== i[0] || cap_data[i] !== exp_d[i]) begin
            miscompares++;
            $display("[TB] FAIL bp_write%0d: got (%b,%b,%h), want (%b,%b,%h)",
                     i, cap_store[i], cap_idx[i], cap_data[i], (i >= 2), i[0], exp_d[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int hs;
      do_reset();
      set_full_pattern();
      run_capture(0, 1'b0);
      start_i = 1'b1;
      tick();
      vectors++;
      if (busy_o !== 1'b0 || wr_valid_o !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL start_in_done: got busy=%b valid=%b, want 0 0", busy_o, wr_valid_o);
      end
      tick();
      start_i = 1'b0;
      vectors++;
      if (busy_o !== 1'b1 || wr_valid_o !== 1'b1 || wr_store_o !== 1'b0 || wr_idx_o !== 1'b0
          || wr_data_o !== 32'h6DB6DB6D) begin
         miscompares++;
         $display("[TB] FAIL start_after_done: got busy=%b valid=%b store=%b idx=%b data=%h, want 1 1 0 0 6db6db6d",
                  busy_o, wr_valid_o, wr_store_o, wr_idx_o, wr_data_o);
      end
      hs = 0;
      wr_ready_i = 1'b1;
      for (int c = 0; c < 50 && !done_o; c++) begin
         if (wr_valid_o) hs++;
         tick();
      end
      wr_ready_i = 1'b0;
      vectors++;
      if (hs !== 4 || done_o !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL b2b_run: got writes=%0d done=%b, want 4 and 1", hs, done_o);
      end
   endtask

   task automatic test_reset_mid();
      int dones;
      do_reset();
      set_full_pattern();
      start_i    = 1'b1;
      wr_ready_i = 1'b1;
      tick();
      start_i = 1'b0;
      tick();
      tick();
      vectors++;
      if (wr_valid_o !== 1'b1 || wr_store_o !== 1'b1 || wr_idx_o !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL mid_position: got valid=%b store=%b idx=%b, want 1 1 0",
                  wr_valid_o, wr_store_o, wr_idx_o);
      end
      rst_n_i = 1'b0;
      tick();
      vectors++;
      if ({wr_valid_o, wr_store_o, wr_idx_o, wr_data_o, busy_o, done_o} !== 37'd0) begin
         miscompares++;
         $display("[TB] FAIL mid_reset_outputs: got valid=%b store=%b idx=%b data=%h busy=%b done=%b, want all 0",
                  wr_valid_o, wr_store_o, wr_idx_o, wr_data_o, busy_o, done_o);
      end
      rst_n_i = 1'b1;
      dones   = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (done_o) dones++;
      end
      vectors++;
      if (dones !== 0) begin
         miscompares++;
         $display("[TB] FAIL mid_no_done: got %0d done pulses, want 0", dones);
      end
      l_sel       = '0;
      s_sel       = '0;
      l_sel[1][2] = 3'b111;
      run_capture(0, 1'b0);
      vectors++;
      if (cap_n !== 4 || cap_store[0] !== 1'b0 || cap_idx[0] !== 1'b0 || cap_data[0] !== 32'h001C0000) begin
         miscompares++;
         $display("[TB] FAIL mid_restart: got writes=%0d first=(%b,%b,%h), want 4 (0,0,001c0000)",
                  cap_n, cap_store[0], cap_idx[0], cap_data[0]);
      end
   endtask

`ifdef CFG_LS_PACK_SKIP_UNCHANGED_EN
   task automatic test_skip();
      do_reset();
      set_full_pattern();
      run_capture(0, 1'b0);
      vectors++;
      if (cap_n !== 4) begin
         miscompares++;
         $display("[TB] FAIL skip_first: got %0d writes, want 4", cap_n);
      end
      tick();
      run_capture(0, 1'b0);
      vectors++;
      if (cap_n !== 0 || done_at !== 5) begin
         miscompares++;
         $display("[TB] FAIL skip_all: got writes=%0d done_at=%0d, want 0 and 5", cap_n, done_at);
      end
      tick();
      s_sel[3][3] = 4'h5;
      run_capture(0, 1'b0);
      vectors++;
      if (cap_n !== 1 || cap_store[0] !== 1'b1 || cap_idx[0] !== 1'b1 || cap_data[0] !== 32'h50000000) begin
         miscompares++;
         $display("[TB] FAIL skip_one: got writes=%0d first=(%b,%b,%h), want 1 (1,1,50000000)",
                  cap_n, cap_store[0], cap_idx[0], cap_data[0]);
      end
   endtask
`endif

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n_i     = 1'b0;
      start_i     = 1'b0;
      wr_ready_i  = 1'b0;
      l_sel       = '0;
      s_sel       = '0;
      test_reset();
      test_single_field();
      test_straddle();
      test_full_pattern();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
`ifdef CFG_LS_PACK_SKIP_UNCHANGED_EN
      test_skip();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cfg_ls_stream_sel_packer.md
Name: cfg_ls_stream_sel_packer

Overview:
- Writer side of the load/store stream-select configuration registers.
- Takes per-bank load and store stream-select fields (KMEM slot 0) and packs them into the flat 32-bit register layout.
- Emits the packed words as a sequence of register-write transactions over a valid/ready port: all load words first, then all store words.
- Sits between the controller-side configuration logic and the cfg register file that feeds the stream-select unpacker.

Parameters:
- N_BANKS_GROUP, 4, number of bank groups.
- N_BANKS_PER_STREAM, 4, banks per stream.
- LOG_N_AGE_PER_STREAM, 3, width of one load-select field (Wl).
- LOG_N_PE_PER_GROUP, 4, width of one store-select field (Ws).
- N_CFG_REGS_LOAD_STREAM, ceil(N_BANKS_GROUP*N_BANKS_PER_STREAM*Wl/32) = 2, load words.
- N_CFG_REGS_STORE_STREAM, ceil(N_BANKS_GROUP*N_BANKS_PER_STREAM*Ws/32) = 2, store words.
- IDX_W, $clog2(max(N_CFG_REGS_LOAD_STREAM, N_CFG_REGS_STORE_STREAM)) min 1, word index width.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  synchronous active-low reset.
- start_i  in  1  pulse: snapshot fields and begin a write sequence.
- l_stream_sel_i  in  [N_BANKS_GROUP][N_BANKS_PER_STREAM][Wl]  load-select fields.
- s_stream_sel_i  in  [N_BANKS_GROUP][N_BANKS_PER_STREAM][Ws]  store-select fields.
- wr_valid_o  out  1  write request valid.
- wr_ready_i  in  1  register file accepts the write.
- wr_store_o  out  1  0 = load register bank, 1 = store register bank.
- wr_idx_o  out  IDX_W  word index within the selected bank.
- wr_data_o  out  32  word data.
- busy_o  out  1  sequence in progress.
- done_o  out  1  one-cycle pulse when the sequence completes.

Behaviour:
- Clock and reset: one clock (clk_i). Reset is synchronous, active-low (rst_n_i). All outputs are 0 at reset: wr_valid_o, wr_store_o, wr_idx_o, wr_data_o, busy_o, done_o.
- Packing:
  - Entry index e = j*N_BANKS_PER_STREAM + k.
  - Field [j][k] occupies flat bits [(e+1)*W-1 -: W].
  - Word n = flat bits [32n+31 : 32n].
  - Bits beyond the last field are 0.
  - Fields may straddle word boundaries.
- Snapshot: on an accepted start, both input arrays are registered. Input changes during a sequence have no effect.
- FSM:
  - IDLE: start_i=1 -> LOAD, idx=0, busy_o=1 next cycle.
  - LOAD: wr_valid_o=1, wr_store_o=0, wr_data_o = load word idx.
    - On handshake (valid & ready): if idx == N_CFG_REGS_LOAD_STREAM-1 -> STORE with idx=0; else idx+1.
  - STORE: same as LOAD with wr_store_o=1 and the store words.
    - On the last handshake -> DONE.
  - DONE: done_o=1, busy_o=0 for exactly one cycle -> IDLE.
- Latency: start at cycle t -> first wr_valid_o at t+1. With wr_ready_i held at 1, one word per cycle; done_o at t+1+NL+NS.
- Handshake:
  - Once wr_valid_o rises, wr_store_o, wr_idx_o and wr_data_o stay stable until the handshake.
  - wr_valid_o never drops without a handshake, except on reset.
- Boundary conditions:
  - start_i while busy or in DONE is ignored (no restart, no queueing).
  - start_i in IDLE the cycle after DONE is accepted.
  - wr_ready_i high while wr_valid_o is low has no effect.
  - rst_n_i low mid-sequence: at the next edge the FSM returns to IDLE and all outputs clear. No partial done_o is issued.

Optional Feature:
- Macro: CFG_LS_PACK_SKIP_UNCHANGED_EN.
- When defined:
  - The block keeps a shadow copy of every word last written by a handshake, plus one shadow-valid bit cleared at reset.
  - With shadow-valid set, a word equal to its shadow is skipped: one cycle with wr_valid_o=0, then the index advances.
  - Shadow-valid is set on the first completed sequence.
  - done_o is still pulsed even if all words are skipped.
- When undefined: every word is always written and no shadow storage exists.

Test Plan:
- Single field: reset; all fields 0 except l[1][2]=3'b111; start; ready=1 -> writes (L,0,0x001C0000), (L,1,0x00000000), (S,0,0), (S,1,0); done_o at t+5.
- Straddle: only l[2][2]=3'b111 -> load word0=0xC0000000, word1=0x00000001.
- Full pattern: all l=3'b101, s[3][3]=4'hA, others 0 -> load words 0x6DB6DB6D, 0x0000B6DB; store words 0x00000000, 0xA0000000.
- Backpressure: ready low 3 cycles per word -> valid, idx, data stable while stalled; inputs changed mid-sequence -> data still matches the snapshot; start_i during busy ignored.
- Reset mid-sequence: rst_n_i low during STORE idx 0 -> next cycle all outputs 0, no done_o; a new start then writes from load word 0.
- Skip (macro on): run the full-pattern sequence twice with identical inputs -> second run has no handshakes and done_o after 4 idle cycles; changing s[3][3] to 4'h5 -> only (S,1,0x50000000) is written.
